// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a show-ahead byte FIFO onto the tx line.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_fifo_drain #(
  parameter int DBIT       = 8,
  parameter int OS         = 16,
  parameter int STOP_TICKS = 16,
  parameter int DIV        = 651
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_rd_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            busy,
  output logic            tx_done_tick
);

  localparam int TMAX = (OS > STOP_TICKS) ? OS : STOP_TICKS;
  localparam int DW   = $clog2(DIV);
  localparam int TW   = $clog2(TMAX);
  localparam int BW   = $clog2(DBIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state, state_n;
  logic [DW-1:0]   div_cnt, div_n;
  logic [TW-1:0]   tick_cnt, tick_n;
  logic [BW-1:0]   bit_cnt, bit_n;
  logic [DBIT-1:0] shreg, shreg_n;
  logic            busy_n, tx_n, pop, done, tick;

`ifdef UART_TX_PARITY_EN
  logic [DBIT-1:0] data_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_byte <= '0;
    end else if (pop) begin
      data_byte <= fifo_rd_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      div_cnt      <= '0;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      fifo_rd      <= 1'b0;
      tx           <= 1'b1;
      busy         <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      state        <= state_n;
      div_cnt      <= div_n;
      tick_cnt     <= tick_n;
      bit_cnt      <= bit_n;
      shreg        <= shreg_n;
      fifo_rd      <= pop;
      tx           <= tx_n;
      busy         <= busy_n;
      tx_done_tick <= done;
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    busy_n  = busy;
    pop     = 1'b0;
    done    = 1'b0;
    tick    = (div_cnt == DW'(DIV - 1));
    if (state != IDLE) begin
      div_n = tick ? '0 : div_cnt + 1'b1;
    end
    unique case (state)
      IDLE: begin
        div_n  = '0;
        busy_n = 1'b0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          busy_n  = 1'b1;
          shreg_n = fifo_rd_data;
          state_n = START;
          tick_n  = '0;
          bit_n   = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt == TW'(OS - 1)) begin
            tick_n  = '0;
            state_n = DATA;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt == TW'(OS - 1)) begin
            tick_n  = '0;
            shreg_n = shreg >> 1;
            if (bit_cnt == BW'(DBIT - 1)) begin
              bit_n = '0;
`ifdef UART_TX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              bit_n = bit_cnt + 1'b1;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (tick_cnt == TW'(OS - 1)) begin
            tick_n  = '0;
            state_n = STOP;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (tick_cnt == TW'(STOP_TICKS - 1)) begin
            tick_n  = '0;
            done    = 1'b1;
            state_n = IDLE;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Line level follows the next state so tx flips on the boundary edge.
  always_comb begin
    tx_n = 1'b1;
    unique case (1'b1)
      (state_n == START): tx_n = 1'b0;
      (state_n == DATA):  tx_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
      (state_n == PARITY): tx_n = ^data_byte;
`endif
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Randomized bench for uart_tx_fifo_drain against a frame-timing model.
// Parity frames are modelled when UART_TX_PARITY_EN is defined.
module tb_uart_tx_fifo_drain;

  localparam int DBIT       = 8;
  localparam int OS         = 16;
  localparam int STOP_TICKS = 16;
  localparam int DIV        = 4;
  localparam int BITCLK     = OS * DIV;
`ifdef UART_TX_PARITY_EN
  localparam int NB = DBIT + 2;
`else
  localparam int NB = DBIT + 1;
`endif
  localparam int FRAME = NB * BITCLK + STOP_TICKS * DIV;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            fifo_empty = 1'b1;
  logic [DBIT-1:0] fifo_rd_data = '0;
  logic            fifo_rd, tx, busy, tx_done_tick;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  int pushes = 0;

  logic [DBIT-1:0] fq[$];
  logic [DBIT-1:0] mq[$];
  bit              m_act = 1'b0;
  int              m_t = 0;
  logic [NB-1:0]   m_bits = '0;

  uart_tx_fifo_drain #(
    .DBIT(DBIT),
    .OS(OS),
    .STOP_TICKS(STOP_TICKS),
    .DIV(DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd(fifo_rd),
    .tx(tx),
    .busy(busy),
    .tx_done_tick(tx_done_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NB-1:0] frame_bits(input logic [DBIT-1:0] b);
    logic [NB-1:0] f;
    f = '0;
    for (int i = 0; i < DBIT; i++) f[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
    f[NB-1] = ^b;
`endif
    return f;
  endfunction

  function automatic logic exp_tx();
    if (!m_act) return 1'b1;
    if (m_t < NB * BITCLK) return m_bits[m_t / BITCLK];
    return 1'b1;
  endfunction

  // FIFO storage and frame model; m_t counts clocks since the pop edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 1'b0;
      m_t   = 0;
    end else begin
      if (fifo_rd) begin
        chk("pop_nonempty", fq.size() != 0, 1);
        if (fq.size() != 0) void'(fq.pop_front());
        pops++;
      end
      if (m_act) begin
        if (m_t < FRAME) m_t++;
        else m_act = 1'b0;
      end
      if (!m_act && mq.size() != 0) begin
        m_act  = 1'b1;
        m_t    = 0;
        m_bits = frame_bits(mq.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    #1;
    fifo_empty   = (fq.size() == 0);
    fifo_rd_data = (fq.size() != 0) ? fq[0] : '0;
  end

  always @(negedge clk) begin
    chk("tx", tx, exp_tx());
    chk("fifo_rd", fifo_rd, m_act && m_t == 0);
    chk("busy", busy, m_act);
    chk("done", tx_done_tick, m_act && m_t == FRAME);
  end

  task automatic push(input logic [DBIT-1:0] b);
    fq.push_back(b);
    mq.push_back(b);
    pushes++;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!m_act && mq.size() == 0 && fq.size() == 0) return;
    end
    chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    rst = 1'b0;

    @(negedge clk);
    push(8'hA5);
    wait_idle(4 * FRAME);

    repeat (2000) @(negedge clk);

    push(8'h00);
    push(8'hFF);
    push(8'h55);
    wait_idle(8 * FRAME);

    push(8'h3C);
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (m_act && m_t == 4 * BITCLK + 20) break;
    end
    chk("mid_sync", m_t, 4 * BITCLK + 20);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    push(8'h81);
    @(negedge clk);
    rst = 1'b0;
    wait_idle(4 * FRAME);

    push(8'h07);
    push(8'h03);
    wait_idle(6 * FRAME);

    for (int n = 0; n < 20; n++) begin
      push(DBIT'($urandom));
      if ($urandom_range(0, 3) == 0) push(DBIT'($urandom));
      repeat ($urandom_range(0, FRAME + 60)) @(negedge clk);
    end
    wait_idle(50 * FRAME);

    chk("pop_count", pops, pushes);
    chk("fifo_left", fq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
